mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Two-requester arbiter and burst sequencer for the single-port unified memory.
//   Shares the memory between instruction fetch (F, read-only) and load/store (D, read/write).
//   Splits each granted burst into single-word memory accesses and returns per-beat acks.
//   Sits between the pipeline front/back ends and the memory block.
// PARAMETERS
//   ADDR_W  32  byte address width
//   DATA_W  32  word width
//   D_FIRST 1   round-robin pointer after reset (1 = D wins the first tie)
// PORTS
//   clock            in  1       system clock, rising edge
//   reset_n          in  1       asynchronous, active-low reset
//   f_req            in  1       F burst request; level, held until f_gnt
//   f_addr           in  ADDR_W  F base byte address, word aligned
//   f_size           in  2       F burst length: 00=1, 01=4, 10=8, 11=16 words
//   f_gnt            out 1       F owns memory (high for whole burst)
//   f_ack            out 1       one pulse per completed F beat; rdata valid
//   d_req            in  1       D burst request; level, held until d_gnt
//   d_addr           in  ADDR_W  D base byte address, word aligned
//   d_size           in  2       D burst length, same encoding as f_size
//   d_rw             in  1       1 = read, 0 = write
//   d_wdata          in  DATA_W  write data for current D beat; held until beat accepted
//   d_ack            out 1       one pulse per completed D beat
//   rdata            out DATA_W  registered read data, valid with f_ack/d_ack on reads
//   mem_enable       out 1       memory access strobe
//   mem_address      out ADDR_W  memory byte address
//   mem_rw           out 1       1 = read, 0 = write
//   mem_access_size  out 2       always 2'b00 (single word)
//   mem_data_in      out DATA_W  write data to memory
//   mem_busy         in  1       memory stall; beat not accepted while high
//   mem_data_out     in  DATA_W  memory read data, valid in acceptance cycle
// BEHAVIOUR
//   Reset (async, reset_n=0): state IDLE; rr pointer = D_FIRST.
//     All outputs 0: gnt, ack, rdata, mem_*.
//   States: IDLE, OWN_F, OWN_D.
//   IDLE:
//     No req: stay IDLE, mem_enable=0.
//     One req: grant that requester.
//     Both reqs: grant the rr-pointer side; pointer flips to the other side.
//     On grant: latch base addr, size, rw (F forces rw=1); beat_cnt=0.
//     Next state OWN_x; gnt rises the cycle after the req is seen.
//   OWN_x:
//     mem_enable=1, mem_address = base + 4*beat_cnt (mod 2^ADDR_W, wraps silently).
//     mem_rw = latched rw; mem_data_in = d_wdata, passed combinationally, D writes only (else 0).
//     Beat accepted = mem_enable & !mem_busy at the rising edge.
//       On acceptance: beat_cnt++; x_ack pulses next cycle.
//       On reads, rdata <= mem_data_out in the same edge.
//     mem_busy high: address/rw/data held, beat_cnt frozen, no ack.
//     Last beat (beat_cnt == len-1) accepted: gnt drops, state -> IDLE next cycle.
//       Final ack still appears in that IDLE cycle.
//   Bus-turnaround: >=1 IDLE cycle between bursts; back-to-back = len+1 cycles/burst min.
//   req dropped mid-burst: ignored, burst runs to completion.
//   req held after last beat: re-arbitrated as a new burst in IDLE.
//   Misaligned base: addr[1:0] ignored and forced to 00 on mem_address.
//   Reset mid-burst: burst abandoned immediately, no further acks; requester must re-issue.
//   rdata holds last read value until next read acceptance; unchanged on writes.
// TESTING
//   1. Reset: reset_n=0 mid-OWN_D burst.
//        -> all outputs 0 asynchronously; state IDLE after release.
//   2. F only, f_addr=32'h80020000, f_size=01, mem_busy=0.
//        -> mem_address 80020000/04/08/0C on 4 consecutive cycles.
//        -> 4 f_ack pulses; rdata matches memory contents.
//   3. D write single, d_addr=32'h80020010, d_wdata=32'hDEADBEEF, mem_busy high 3 cycles.
//        -> mem_rw=0, address/data stable 4 cycles, exactly one d_ack.
//   4. f_req, d_req same cycle from reset (D_FIRST=1), both size 00.
//        -> D granted first, then F after 1 IDLE cycle.
//        -> repeat: F then D (round-robin alternates).
//   5. Wrap: d_addr=32'hFFFFFFF8, d_size=01, read.
//        -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
//   6. d_req dropped after first beat of 8-word burst.
//        -> all 8 beats and 8 d_acks still issued, then IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose: two-requester (F read-only, D read/write) arbiter that splits granted bursts into single-word memory beats.
// Latency: grant one cycle after req; one beat per cycle while owning; ack one cycle after each accepted beat; >=1 idle cycle between bursts.
// Backpressure: mem_busy stalls the current beat (address/rw/data held, beat counter frozen, no ack).
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int D_FIRST = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [1:0]        f_size,
    output logic              f_gnt,
    output logic              f_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_rw,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_rw,
    output logic [1:0]        mem_access_size,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_F = 2'd1,
        S_OWN_D = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_rr_d;        // 1: D wins the next tie
    logic [ADDR_W-1:0]   r_base;
    logic [3:0]          r_len_m1;
    logic [3:0]          r_cnt;
    logic                r_rw;
    logic                r_f_ack;
    logic                r_d_ack;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_own;
    logic                w_accept;
    logic                w_last;
    logic                w_grant_f;
    logic                w_grant_d;
    logic                w_tie;
    logic [ADDR_W-1:0]   w_offset;
    logic                w_unused;

    // Byte offsets below a word are meaningless for single-word beats.
    assign w_unused = ^{f_addr[1:0], d_addr[1:0]};

    // Burst length code to (length - 1).
    function automatic logic [3:0] len_m1(input logic [1:0] size);
        case (size)
            2'b00:   return 4'd0;
            2'b01:   return 4'd3;
            2'b10:   return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    assign w_own    = (r_state != S_IDLE);
    assign w_accept = w_own & ~mem_busy;
    assign w_last   = (r_cnt == r_len_m1);
    assign w_offset = {{(ADDR_W-6){1'b0}}, r_cnt, 2'b00};

    // Next-state and grant decision; ties go to the round-robin side.
    always_comb begin
        w_next_state = r_state;
        w_grant_f    = 1'b0;
        w_grant_d    = 1'b0;
        w_tie        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (f_req && d_req) begin
                    w_tie     = 1'b1;
                    w_grant_d = r_rr_d;
                    w_grant_f = ~r_rr_d;
                end else if (d_req) begin
                    w_grant_d = 1'b1;
                end else if (f_req) begin
                    w_grant_f = 1'b1;
                end
                if (w_grant_d) begin
                    w_next_state = S_OWN_D;
                end else if (w_grant_f) begin
                    w_next_state = S_OWN_F;
                end
            end
            S_OWN_F, S_OWN_D: begin
                if (w_accept && w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Burst context latched at grant, beat counter advanced on acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_d   <= (D_FIRST != 0);
            r_base   <= '0;
            r_len_m1 <= '0;
            r_cnt    <= '0;
            r_rw     <= 1'b0;
        end else begin
            if (w_tie) begin
                r_rr_d <= ~r_rr_d;
            end
            if (w_grant_d) begin
                r_base   <= {d_addr[ADDR_W-1:2], 2'b00};
                r_len_m1 <= len_m1(d_size);
                r_cnt    <= '0;
                r_rw     <= d_rw;
            end else if (w_grant_f) begin
                r_base   <= {f_addr[ADDR_W-1:2], 2'b00};
                r_len_m1 <= len_m1(f_size);
                r_cnt    <= '0;
                r_rw     <= 1'b1;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Per-beat acks and read data capture, one cycle after acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_f_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_f_ack <= w_accept & (r_state == S_OWN_F);
            r_d_ack <= w_accept & (r_state == S_OWN_D);
            if (w_accept && r_rw) begin
                r_rdata <= mem_data_out;
            end
        end
    end

    assign f_gnt           = (r_state == S_OWN_F);
    assign d_gnt           = (r_state == S_OWN_D);
    assign f_ack           = r_f_ack;
    assign d_ack           = r_d_ack;
    assign rdata           = r_rdata;
    assign mem_enable      = w_own;
    assign mem_address     = w_own ? (r_base + w_offset) : '0;
    assign mem_rw          = w_own & r_rw;
    assign mem_access_size = 2'b00;
    assign mem_data_in     = ((r_state == S_OWN_D) && !r_rw) ? d_wdata : '0;

endmodule
